// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns the result on a valid/ready response.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    cmd_ready_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    timeout_hit_s;

    // The limit is reached when this low-pready cycle would bring the wait count to TIMEOUT_CYCLES.
    always_comb begin
        cnt_inc_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        timeout_hit_s = 1'b0;
        if (TO_EN && (cnt_inc_s == TO_VAL)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer FSM with all interface outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_WIDTH{1'b0}};
            pwdata_r      <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_r     <= ST_SETUP;
                        cmd_ready_r <= 1'b0;
                        psel_r      <= 1'b1;
                        pwrite_r    <= cmd_write;
                        paddr_r     <= cmd_addr;
                        pwdata_r    <= cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_ACCESS: begin
                    // A completing slave beats the timeout in the same cycle.
                    if (pready) begin
                        state_r       <= ST_RESP;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
                        rsp_err_r     <= pslverr;
                        rsp_timeout_r <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r       <= ST_RESP;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus random bench for apb_master_bridge with a wait-state slave
// model and a transaction-level expectation model.
module tb_apb_master_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    // slave configuration for the current transfer
    int            wait_cfg = 0;
    logic [DW-1:0] rdata_cfg = '0;
    logic          err_cfg = 1'b0;
    int            acc_cnt = 0;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Slave: asserts pready on ACCESS cycle number wait_cfg; garbage data otherwise.
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  <= (acc_cnt == wait_cfg);
            prdata  <= (acc_cnt == wait_cfg) ? rdata_cfg : $urandom;
            pslverr <= (acc_cnt == wait_cfg) ? err_cfg : 1'($urandom_range(0, 1));
            acc_cnt <= acc_cnt + 1;
        end else begin
            pready  <= 1'b0;
            prdata  <= $urandom;
            pslverr <= 1'($urandom_range(0, 1));
            acc_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        @(negedge clk);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
        cmd_write = ~wr;
    endtask

    // Expected outcome from the transfer rules: a slave needing w wait states
    // finishes after w+1 ACCESS cycles unless w reaches the timeout limit.
    task automatic watch(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input logic er);
        int setup_n = 0;
        int acc_n = 0;
        int cyc = 0;
        int bad_ctl = 0;
        int bad_hold = 0;
        logic to;
        int exp_acc;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_wd;
        wait_cfg  = waits;
        rdata_cfg = rd;
        err_cfg   = er;
        to      = (TO != 0) && (waits >= TO);
        exp_acc = to ? TO : waits + 1;
        exp_rd  = (to || wr) ? '0 : rd;
        exp_wd  = wr ? wd : '0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== 1'b1) begin
                if (psel && !penable) setup_n++;
                if (psel && penable) acc_n++;
                if (penable && !psel) bad_ctl++;
                if (cmd_ready !== 1'b0) bad_ctl++;
                if (psel && (paddr !== a || pwrite !== wr || pwdata !== exp_wd)) bad_hold++;
            end
        end
        chk("rsp_seen", rsp_valid, 1'b1);
        chk("latency", cyc, exp_acc + 2);
        chk("setup_cycles", setup_n, 1);
        chk("access_cycles", acc_n, exp_acc);
        chk("ctl_protocol", bad_ctl, 0);
        chk("addr_data_hold", bad_hold, 0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, to | er);
        chk("rsp_timeout", rsp_timeout, to);
        chk("resp_no_apb", {psel, penable, cmd_ready}, 3'b000);
    endtask

    task automatic finish_rsp(input int hold);
        logic [DW+1:0] snap;
        int bad = 0;
        snap = {rsp_rdata, rsp_err, rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({rsp_rdata, rsp_err, rsp_timeout} !== snap || rsp_valid !== 1'b1 ||
                cmd_ready !== 1'b0 || psel !== 1'b0) bad++;
        end
        chk("rsp_hold", bad, 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 1'b0);
        chk("ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        logic [DW+1:0] snap;
        int            bad;

        // reset state
        #12;
        chk("rst_apb", {psel, penable, pwrite}, 3'b000);
        chk("rst_paddr", paddr, '0);
        chk("rst_pwdata", pwdata, '0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        chk("rst_rdata", rsp_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1'b1);

        // directed transfers
        issue(1'b1, 10'h3A5, 32'hDEADBEEF);
        watch(1'b1, 10'h3A5, 32'hDEADBEEF, 0, 32'h0BAD0BAD, 1'b0);
        finish_rsp(0);
        issue(1'b0, 10'h004, 32'h11111111);
        watch(1'b0, 10'h004, 32'h11111111, 2, 32'h12345678, 1'b0);
        finish_rsp(1);
        issue(1'b0, 10'h010, 32'h0);
        watch(1'b0, 10'h010, 32'h0, 1, 32'hFFFF0000, 1'b1);
        finish_rsp(0);
        issue(1'b0, 10'h020, 32'h0);
        watch(1'b0, 10'h020, 32'h0, 1000, 32'hAAAA5555, 1'b0);
        finish_rsp(2);
        issue(1'b0, 10'h024, 32'h0);
        watch(1'b0, 10'h024, 32'h0, TO - 1, 32'h5A5A5A5A, 1'b0);
        finish_rsp(0);
        issue(1'b1, 10'h028, 32'h76543210);
        watch(1'b1, 10'h028, 32'h76543210, TO, 32'h0, 1'b0);
        finish_rsp(0);

        // response back-pressure with the next command already pending
        issue(1'b0, 10'h100, 32'h0);
        watch(1'b0, 10'h100, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        cmd_write = 1'b1;
        cmd_addr  = 10'h155;
        cmd_wdata = 32'h01234567;
        cmd_valid = 1'b1;
        snap = {rsp_rdata, rsp_err, rsp_timeout};
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({rsp_rdata, rsp_err, rsp_timeout} !== snap || rsp_valid !== 1'b1 ||
                cmd_ready !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) bad++;
        end
        chk("backpressure_hold", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_rsp_cleared", rsp_valid, 1'b0);
        @(negedge clk);
        chk("bp_idle_gap", {psel, cmd_ready}, 2'b01);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        watch(1'b1, 10'h155, 32'h01234567, 1, 32'h0, 1'b0);
        finish_rsp(0);

        // random transfers
        for (int n = 0; n < 16; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 10'($urandom);
            wd = $urandom;
            rd = $urandom;
            er = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 5);
            issue(wr, a, wd);
            watch(wr, a, wd, w, rd, er);
            finish_rsp($urandom_range(0, 3));
        end

        // reset in the middle of ACCESS
        issue(1'b0, 10'h0F0, 32'h0);
        wait_cfg = 1000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_access", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drop", {psel, penable, rsp_valid}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        issue(1'b0, 10'h0F4, 32'h0);
        watch(1'b0, 10'h0F4, 32'h0, 0, 32'h600DF00D, 1'b0);
        finish_rsp(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
